// File: rtl/sha_message_schedule.sv
// SHA-256 message-schedule generator: streams (t, Wt, Kt) for one 512-bit block,
// one round per unstalled cycle, from a 16-word sliding window and a K ROM.
module sha_message_schedule #(
    parameter int NUM_ROUNDS = 64
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [511:0] block,
    output logic         ready,
    input  logic         hold,
    output logic         round_valid,
    output logic [5:0]   t,
    output logic [31:0]  Wt,
    output logic [31:0]  Kt,
    output logic         last
);

    typedef enum logic {IDLE, RUN} state_e;

    localparam logic [5:0] T_LAST = 6'(NUM_ROUNDS - 1);

    localparam logic [31:0] K_ROM [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    state_e      state_q, state_d;
    logic [5:0]  t_q, t_d;
    logic [31:0] win_q [16];
    logic [31:0] win_d [16];
    logic        run;
    logic        at_last;

    assign run     = (state_q == RUN);
    assign at_last = run && (t_q == T_LAST);

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        win_d   = win_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    t_d     = '0;
                    for (int i = 0; i < 16; i++) begin
                        win_d[i] = block[511 - 32*i -: 32];
                    end
                end
            end
            RUN: begin
                if (!hold) begin
                    for (int i = 0; i < 15; i++) begin
                        win_d[i] = win_q[i+1];
                    end
                    win_d[15] = sig1(win_q[14]) + win_q[9]
                              + sig0(win_q[1]) + win_q[0];
                    // t parks at 0 in IDLE so the next block starts clean
                    if (at_last) begin
                        state_d = IDLE;
                        t_d     = '0;
                    end else begin
                        t_d = t_q + 6'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            t_q     <= '0;
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            win_q   <= win_d;
        end
    end

    assign ready       = !run;
    assign round_valid = run;
    assign t           = t_q;
    assign Wt          = run ? win_q[0] : 32'h0;
    assign Kt          = run ? K_ROM[t_q] : 32'h0;
    assign last        = at_last;

endmodule

// File: tb/tb_sha_message_schedule.sv
// Directed bench for sha_message_schedule: reset, abc block, hold, ignored
// start, mid-run reset and back-to-back blocks.
module tb_sha_message_schedule;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [511:0] block;
    logic         ready;
    logic         hold;
    logic         round_valid;
    logic [5:0]   t;
    logic [31:0]  Wt;
    logic [31:0]  Kt;
    logic         last;

    int n_chk  = 0;
    int n_fail = 0;

    sha_message_schedule #(.NUM_ROUNDS(64)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .block       (block),
        .ready       (ready),
        .hold        (hold),
        .round_valid (round_valid),
        .t           (t),
        .Wt          (Wt),
        .Kt          (Kt),
        .last        (last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Reference schedule expanded the textbook way over all 64 words
    task automatic expand(input logic [511:0] blk, output logic [31:0] w [64]);
        logic [31:0] s0, s1;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = s1 + w[i-7] + s0 + w[i-16];
        end
    endtask

    // Entered #1 after the accepting edge; leaves #1 after the exit edge.
    task automatic run_block(input logic [511:0] blk, input bit is_abc,
                             input int hold_t, input int hold_n,
                             input int poke_t, input bit keep_start,
                             output int valid_cycles);
        logic [31:0] w [64];
        int r, held, lasts, guard;
        expand(blk, w);
        r = 0; held = 0; lasts = 0; guard = 0;
        valid_cycles = 0;
        while (r < 64 && guard < 200) begin
            guard++;
            chk("rv", {63'b0, round_valid}, 64'd1);
            chk("rdy", {63'b0, ready}, 64'd0);
            chk("t", {58'b0, t}, 64'(r));
            chk("wt", {32'b0, Wt}, {32'b0, w[r]});
            chk("last", {63'b0, last}, {63'b0, r == 63});
            if (round_valid) valid_cycles++;
            if (last) lasts++;
            if (r == 0)  chk("k0",  {32'b0, Kt}, 64'h428a2f98);
            if (r == 17) chk("k17", {32'b0, Kt}, 64'hefbe4786);
            if (r == 62) chk("k62", {32'b0, Kt}, 64'hbef9a3f7);
            if (r == 63) chk("k63", {32'b0, Kt}, 64'hc67178f2);
            if (is_abc) begin
                if (r == 0)  chk("w0",  {32'b0, Wt}, 64'h61626380);
                if (r == 15) chk("w15", {32'b0, Wt}, 64'h00000018);
                if (r == 16) chk("w16", {32'b0, Wt}, 64'h61626380);
                if (r == 17) chk("w17", {32'b0, Wt}, 64'h000f0000);
            end
            if (r == hold_t && held < hold_n) begin
                hold = 1'b1;
                held++;
            end else begin
                hold = 1'b0;
                r++;
            end
            if (keep_start) begin
                start = 1'b1;
            end else if (r == poke_t) begin
                start = 1'b1;
                block = ~blk;
            end else begin
                start = 1'b0;
            end
            step();
        end
        hold = 1'b0;
        chk("end_rv", {63'b0, round_valid}, 64'd0);
        chk("end_rdy", {63'b0, ready}, 64'd1);
        chk("end_t", {58'b0, t}, 64'd0);
        chk("end_wt", {32'b0, Wt}, 64'd0);
        chk("end_kt", {32'b0, Kt}, 64'd0);
        chk("lasts", 64'(lasts), 64'd1);
    endtask

    logic [511:0] abc, blk2, blk3;
    int nvalid;

    initial begin
        abc  = {32'h61626380, 448'b0, 32'h00000018};
        blk2 = {128'h0123456789abcdef_fedcba9876543210,
                128'hdeadbeef_cafef00d_13579bdf_2468ace0,
                128'h00000001_80000000_ffffffff_7fffffff,
                128'h11111111_22222222_33333333_44444444};
        blk3 = {16{32'ha5a5_5a5a}};

        // reset with start asserted
        reset_n = 1'b0; start = 1'b1; hold = 1'b0; block = abc;
        step(); step();
        chk("rst_rdy", {63'b0, ready}, 64'd1);
        chk("rst_rv", {63'b0, round_valid}, 64'd0);
        chk("rst_t", {58'b0, t}, 64'd0);
        chk("rst_wt", {32'b0, Wt}, 64'd0);
        chk("rst_kt", {32'b0, Kt}, 64'd0);
        chk("rst_last", {63'b0, last}, 64'd0);

        // abc: hold 3 cycles at t=5, stray start at t=30
        reset_n = 1'b1; start = 1'b1; block = abc;
        step();
        start = 1'b0;
        run_block(abc, 1'b1, 5, 3, 30, 1'b0, nvalid);
        chk("valid67", 64'(nvalid), 64'd67);

        // idle must ignore hold
        hold = 1'b1;
        step();
        chk("idle_hold_rdy", {63'b0, ready}, 64'd1);
        hold = 1'b0;

        // mid-run reset at t=20
        start = 1'b1; block = blk2;
        step();
        start = 1'b0;
        for (int i = 0; i < 20; i++) step();
        chk("pre_rst_t", {58'b0, t}, 64'd20);
        reset_n = 1'b0;
        step();
        chk("mrst_rdy", {63'b0, ready}, 64'd1);
        chk("mrst_rv", {63'b0, round_valid}, 64'd0);
        chk("mrst_t", {58'b0, t}, 64'd0);
        chk("mrst_wt", {32'b0, Wt}, 64'd0);

        // restart, then back-to-back with start held high
        reset_n = 1'b1; start = 1'b1; block = blk2;
        step();
        run_block(blk2, 1'b0, -1, 0, -1, 1'b1, nvalid);
        block = blk3;
        step();
        chk("b2b_rv", {63'b0, round_valid}, 64'd1);
        chk("b2b_t", {58'b0, t}, 64'd0);
        chk("b2b_wt", {32'b0, Wt}, 64'ha5a55a5a);
        start = 1'b0;
        run_block(blk3, 1'b0, -1, 0, -1, 1'b0, nvalid);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
